// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser
// Packet-framing stage in front of the UART ALU. Parses a byte stream of
// [opcode][reserved][len lo][len hi][32-bit LE operand]... and emits one
// handshaked command beat per operand, tagged with first/last markers.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   byte_i/_valid_i   incoming UART byte, qualified by valid
//   byte_ready_o      parser accepts a byte this cycle (low only in EMIT)
//   cmd_valid_o       command beat valid; held until cmd_ready_i
//   cmd_ready_i       ALU accepts the beat
//   opcode_o          opcode of the current packet
//   operand_o         received 32-bit word, zero-extended to OPND_W
//   first_o, last_o   first / last operand of the packet
//   err_o             one-cycle pulse when a packet is rejected
//
// Build option: ALU_CMD_PARSER_OPCODE_FILTER_EN restricts accepted opcodes
// to 0xEC, 0xAD, 0xAC and 0xD1; other opcodes are rejected and their payload
// dropped. Without it every opcode is forwarded.
//
// state | meaning
// ------+-------------------------------------------------------------
// OPC   | waiting for opcode byte
// RSVD  | discarding reserved byte
// LENL  | capturing length low byte
// LENH  | capturing length high byte, validating length/opcode
// DATA  | shifting operand bytes in, LSB first
// EMIT  | presenting command beat, byte input stalled
// DROP  | discarding payload of a rejected packet

module alu_cmd_parser #(
  parameter int LEN_W  = 16,
  parameter int OPND_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [7:0]        opcode_o,
  output logic [OPND_W-1:0] operand_o,
  output logic              first_o,
  output logic              last_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_OPC, S_RSVD, S_LENL, S_LENH, S_DATA, S_EMIT, S_DROP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      word_q, word_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             byte_fire;
  logic             beat_fire;
  logic [LEN_W-1:0] len_full;
  logic             len_ok;
  logic             opcode_ok;

  assign byte_ready_o = (state_q != S_EMIT);
  assign cmd_valid_o  = (state_q == S_EMIT);
  assign opcode_o     = opcode_q;
  assign operand_o    = OPND_W'(word_q);
  assign first_o      = first_q;
  assign last_o       = last_q;
  assign err_o        = err_q;

  assign byte_fire = byte_valid_i && byte_ready_o;
  assign beat_fire = cmd_valid_o && cmd_ready_i;

  // Length as seen while the high byte is on the input.
  assign len_full = LEN_W'({byte_i, len_lo_q});
  assign len_ok   = (len_full >= LEN_W'(8)) && (len_full[1:0] == 2'b00);

`ifdef ALU_CMD_PARSER_OPCODE_FILTER_EN
  assign opcode_ok = (opcode_q == 8'hEC) || (opcode_q == 8'hAD) ||
                     (opcode_q == 8'hAC) || (opcode_q == 8'hD1);
`else
  assign opcode_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    last_d   = last_q;
    err_d    = 1'b0;

    case (state_q)
      S_OPC: begin
        if (byte_fire) begin
          opcode_d = byte_i;
          state_d  = S_RSVD;
        end
      end
      S_RSVD: begin
        if (byte_fire) state_d = S_LENL;
      end
      S_LENL: begin
        if (byte_fire) begin
          len_lo_d = byte_i;
          state_d  = S_LENH;
        end
      end
      S_LENH: begin
        if (byte_fire) begin
          if (len_ok && opcode_ok) begin
            rem_d   = len_full - LEN_W'(4);
            cnt_d   = 2'd0;
            first_d = 1'b1;
            state_d = S_DATA;
          end else begin
            err_d = 1'b1;
            if (len_full <= LEN_W'(4)) begin
              rem_d   = '0;
              state_d = S_OPC;
            end else begin
              rem_d   = len_full - LEN_W'(4);
              state_d = S_DROP;
            end
          end
        end
      end
      S_DATA: begin
        if (byte_fire) begin
          word_d = {byte_i, word_q[31:8]};
          rem_d  = rem_q - LEN_W'(1);
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            last_d  = (rem_q == LEN_W'(1));
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (beat_fire) begin
          first_d = 1'b0;
          state_d = (rem_q == '0) ? S_OPC : S_DATA;
        end
      end
      S_DROP: begin
        if (byte_fire) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_OPC;
        end
      end
      default: state_d = S_OPC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_OPC;
      opcode_q <= '0;
      len_lo_q <= '0;
      rem_q    <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_parser.sv
module tb_alu_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;
  logic [7:0]  opcode_o;
  logic [32:0] operand_o;
  logic        first_o;
  logic        last_o;
  logic        err_o;

  alu_cmd_parser dut (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .opcode_o     (opcode_o),
    .operand_o    (operand_o),
    .first_o      (first_o),
    .last_o       (last_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [32:0] opnd;
    logic        first;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && cmd_valid_o && cmd_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual op=%0h opnd=%0h required none",
                 opcode_o, operand_o);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_opcode",  64'(opcode_o),  64'(e.op));
        chk("beat_operand", 64'(operand_o), 64'(e.opnd));
        chk("beat_first",   64'(first_o),   64'(e.first));
        chk("beat_last",    64'(last_o),    64'(e.last));
      end
    end
  end

  always @(negedge clk) if (err_o) err_seen++;

  function automatic void push(input logic [7:0] op, input logic [32:0] v,
                               input logic f, input logic l);
    beat_t b;
    b.op = op; b.opnd = v; b.first = f; b.last = l;
    exp_q.push_back(b);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (byte_ready_o) break;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout actual=stalled required=accepted");
        break;
      end
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_valid"},  64'(cmd_valid_o),  64'd0);
    chk({tag, "_byte_ready"}, 64'(byte_ready_o), 64'd1);
    chk({tag, "_err"},        64'(err_o),        64'd0);
    chk({tag, "_opcode"},     64'(opcode_o),     64'd0);
    chk({tag, "_operand"},    64'(operand_o),    64'd0);
    chk({tag, "_first"},      64'(first_o),      64'd0);
    chk({tag, "_last"},       64'(last_o),       64'd0);
  endtask

  task automatic stall_check();
    int n;
    n = 0;
    while (!cmd_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 64'(cmd_valid_o), 64'd1);
    repeat (5) begin
      chk("stall_operand",    64'(operand_o),    64'd1);
      chk("stall_first",      64'(first_o),      64'd1);
      chk("stall_last",       64'(last_o),       64'd0);
      chk("stall_opcode",     64'(opcode_o),     64'hAD);
      chk("stall_byte_ready", 64'(byte_ready_o), 64'd0);
      chk("stall_valid",      64'(cmd_valid_o),  64'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_ready_i = 1'b1;
  endtask

  initial begin
    logic [7:0] pkt[$];
    int e0;

    @(negedge clk);
    chk_reset_vals("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Echo packet, with byte_valid gaps mid-packet.
    push(8'hEC, 33'h012345678, 1'b1, 1'b1);
    e0 = err_seen;
    send_seq('{8'hEC, 8'h00, 8'h08, 8'h00});
    idle(3);
    send_byte(8'h78);
    idle(2);
    pkt = '{8'h56, 8'h34, 8'h12};
    send_seq(pkt);
    drain("echo_drain");
    chk("echo_err", 64'(err_seen - e0), 64'd0);
    chk("echo_ready_after", 64'(byte_ready_o), 64'd1);

    // Add packet with backpressure on beat 1.
    push(8'hAD, 33'd1, 1'b1, 1'b0);
    push(8'hAD, 33'd2, 1'b0, 1'b1);
    cmd_ready_i = 1'b0;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00};
    fork
      send_seq(pkt);
      stall_check();
    join
    drain("add_drain");

    // Bad length: dropped payload, then a good packet.
    e0 = err_seen;
    push(8'hEC, 33'd1, 1'b1, 1'b1);
    pkt = '{8'hD1, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
            8'hEC, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_seq(pkt);
    drain("badlen_drain");
    chk("badlen_err", 64'(err_seen - e0), 64'd1);

    // Short length.
    e0 = err_seen;
    push(8'hEC, 33'h0FFFFFFFF, 1'b1, 1'b1);
    pkt = '{8'hAC, 8'h00, 8'h04, 8'h00,
            8'hEC, 8'h00, 8'h08, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_seq(pkt);
    drain("short_drain");
    chk("short_err", 64'(err_seen - e0), 64'd1);

    // Reset mid-packet.
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
    send_seq(pkt);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset_vals("rstmid");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    push(8'hEC, 33'd5, 1'b1, 1'b1);
    pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_seq(pkt);
    drain("rstmid_drain");

    // Opcode filter build option.
    e0 = err_seen;
`ifdef ALU_CMD_PARSER_OPCODE_FILTER_EN
    pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(pkt);
    idle(4);
    drain("filter_drain");
    chk("filter_err", 64'(err_seen - e0), 64'd1);
`else
    push(8'h55, 33'h004030201, 1'b1, 1'b1);
    pkt = '{8'h55, 8'h00, 8'h08, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(pkt);
    drain("nofilter_drain");
    chk("nofilter_err", 64'(err_seen - e0), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
